// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
//   DEF_CNT_W : default counter/divisor width
//   DEF_DIV   : default divisor loaded at reset
//   MIN_DIV   : smallest divisor a channel accepts
//   ch_width  : channel-index width, never below one bit
package clk_div_pkg;

  localparam int DEF_CNT_W = 32'sd24;
  localparam int DEF_DIV   = 32'sd15_000_000;
  localparam int MIN_DIV   = 32'sd2;

  // A single channel still needs a one-bit index so the config port exists.
  function automatic int ch_width(input int num_ch);
    if (num_ch <= 32'sd1) begin
      return 32'sd1;
    end else begin
      return $clog2(num_ch);
    end
  endfunction

endpackage

// File: rtl/programmable_clock_divider_if.sv
// Configuration bus of the programmable clock divider.
//   cfg_wr_in   : write strobe, one cycle per write
//   cfg_ch_in   : target channel index
//   cfg_div_in  : divisor to apply
//   cfg_en_in   : channel enable written together with the divisor
//   cfg_err_out : one-cycle pulse, previous write was rejected
// master = configuring agent, slave = divider.
interface programmable_clock_divider_if
  import clk_div_pkg::*;
#(
  parameter int CH_W  = 2,
  parameter int CNT_W = DEF_CNT_W
);

  logic             cfg_wr_in;
  logic [CH_W-1:0]  cfg_ch_in;
  logic [CNT_W-1:0] cfg_div_in;
  logic             cfg_en_in;
  logic             cfg_err_out;

  modport master (
    output cfg_wr_in, cfg_ch_in, cfg_div_in, cfg_en_in,
    input  cfg_err_out
  );

  modport slave (
    input  cfg_wr_in, cfg_ch_in, cfg_div_in, cfg_en_in,
    output cfg_err_out
  );

endinterface

// File: rtl/clk_div_channel.sv
// One divider channel: period counter, active/shadow divisor and
// registered divided-clock / tick outputs.
//   clk_in, rst_in : system clock, synchronous active-high reset
//   cfg_wr         : already-validated write aimed at this channel
//   cfg_div        : divisor of that write (>= 2)
//   cfg_en         : enable of that write
//   div_clk        : divided clock, high floor(D/2) of every D cycles
//   div_tick       : one-cycle pulse on the last cycle of each period
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             cfg_wr,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_en,
  output logic             div_clk,
  output logic             div_tick
);

  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_C  = CNT_W'(0);
  localparam logic [CNT_W-1:0] DEF_D_C = CNT_W'(DEFAULT_DIV);

  logic             en_r, en_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [CNT_W-1:0] d_act_r, d_act_nxt_s;
  logic [CNT_W-1:0] d_pend_r, d_pend_nxt_s;
  logic             pend_v_r, pend_v_nxt_s;
  logic             clk_q_r, clk_nxt_s;
  logic             tick_q_r, tick_nxt_s;
  logic             wrap_s;

  // Next-state of counter and divisors, then outputs derived from that next state.
  always_comb begin
    en_nxt_s     = en_r;
    cnt_nxt_s    = cnt_r;
    d_act_nxt_s  = d_act_r;
    d_pend_nxt_s = d_pend_r;
    pend_v_nxt_s = pend_v_r;
    wrap_s       = (cnt_r == (d_act_r - ONE_C));

    if (cfg_wr && !cfg_en) begin
      en_nxt_s     = 1'b0;
      cnt_nxt_s    = ZERO_C;
      pend_v_nxt_s = 1'b0;
      d_act_nxt_s  = cfg_div;
    end else if (cfg_wr && !en_r) begin
      // Period starts at the enabling edge.
      en_nxt_s    = 1'b1;
      cnt_nxt_s   = ZERO_C;
      d_act_nxt_s = cfg_div;
    end else if (en_r) begin
      if (wrap_s) begin
        cnt_nxt_s = ZERO_C;
        // A write landing on the wrap edge is newer than any pending divisor.
        if (cfg_wr) begin
          d_act_nxt_s  = cfg_div;
          pend_v_nxt_s = 1'b0;
        end else if (pend_v_r) begin
          d_act_nxt_s  = d_pend_r;
          pend_v_nxt_s = 1'b0;
        end else begin
          d_act_nxt_s  = d_act_r;
        end
      end else begin
        cnt_nxt_s = cnt_r + ONE_C;
        // Retune is deferred to the wrap so the running period is glitch-free.
        if (cfg_wr) begin
          d_pend_nxt_s = cfg_div;
          pend_v_nxt_s = 1'b1;
        end else begin
          d_pend_nxt_s = d_pend_r;
        end
      end
    end else begin
      cnt_nxt_s = ZERO_C;
    end

    clk_nxt_s  = en_nxt_s && (cnt_nxt_s < (d_act_nxt_s >> 1'b1));
    tick_nxt_s = en_nxt_s && (cnt_nxt_s == (d_act_nxt_s - ONE_C));
  end

  // Channel state and output registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      en_r     <= 1'b0;
      cnt_r    <= ZERO_C;
      d_act_r  <= DEF_D_C;
      d_pend_r <= DEF_D_C;
      pend_v_r <= 1'b0;
      clk_q_r  <= 1'b0;
      tick_q_r <= 1'b0;
    end else begin
      en_r     <= en_nxt_s;
      cnt_r    <= cnt_nxt_s;
      d_act_r  <= d_act_nxt_s;
      d_pend_r <= d_pend_nxt_s;
      pend_v_r <= pend_v_nxt_s;
      clk_q_r  <= clk_nxt_s;
      tick_q_r <= tick_nxt_s;
    end
  end

  assign div_clk  = clk_q_r;
  assign div_tick = tick_q_r;

endmodule

// File: rtl/programmable_clock_divider.sv
// Multi-channel programmable clock divider. Each channel divides clk_in by a
// runtime divisor D >= 2 and emits a registered ~50% clock plus a tick.
//   clk_in   : system clock, all logic on posedge
//   rst_in   : synchronous active-high reset
//   cfg      : configuration bus (slave side); write validation and the
//              rejection pulse cfg_err_out live here
//   clk_out  : divided clock per channel
//   tick_out : last-cycle-of-period pulse per channel
module programmable_clock_divider
  import clk_div_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  programmable_clock_divider_if.slave cfg,
  output logic [NUM_CH-1:0]     clk_out,
  output logic [NUM_CH-1:0]     tick_out
);

  localparam int CH_W = ch_width(NUM_CH);
  // One extra bit so NUM_CH itself is representable when it is a power of two.
  localparam logic [CH_W:0]    NUM_CH_C  = (CH_W + 1)'(NUM_CH);
  localparam logic [CNT_W-1:0] MIN_DIV_C = CNT_W'(MIN_DIV);

  logic              div_ok_s;
  logic              ch_ok_s;
  logic              cfg_valid_s;
  logic              cfg_err_nxt_s;
  logic              cfg_err_r;
  logic [NUM_CH-1:0] ch_wr_s;

  assign div_ok_s      = (cfg.cfg_div_in >= MIN_DIV_C);
  assign ch_ok_s       = ({1'b0, cfg.cfg_ch_in} < NUM_CH_C);
  assign cfg_valid_s   = cfg.cfg_wr_in && div_ok_s && ch_ok_s;
  assign cfg_err_nxt_s = cfg.cfg_wr_in && !(div_ok_s && ch_ok_s);

  // Rejection flag: pulses for one cycle after a bad write, cleared otherwise.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cfg_err_r <= 1'b0;
    end else begin
      cfg_err_r <= cfg_err_nxt_s;
    end
  end

  assign cfg.cfg_err_out = cfg_err_r;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_wr_s[i] = cfg_valid_s && (cfg.cfg_ch_in == CH_W'(i));

    clk_div_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .cfg_wr   (ch_wr_s[i]),
      .cfg_div  (cfg.cfg_div_in),
      .cfg_en   (cfg.cfg_en_in),
      .div_clk  (clk_out[i]),
      .div_tick (tick_out[i])
    );
  end

endmodule

// File: tb/tb_programmable_clock_divider.sv
// Directed bench for programmable_clock_divider with NUM_CH=4, CNT_W=4,
// DEFAULT_DIV=6. Inputs change 1 ns after a rising edge and outputs are
// sampled at the same point, i.e. they show the state registered at that edge.
module tb_programmable_clock_divider;

  logic       clk;
  logic       rst;
  logic [3:0] clk_out;
  logic [3:0] tick_out;
  int         n_tests;
  int         n_fail;
  int         k3;

  programmable_clock_divider_if #(.CH_W(2), .CNT_W(4)) cfg_bus ();

  programmable_clock_divider #(
    .NUM_CH      (4),
    .CNT_W       (4),
    .DEFAULT_DIV (6)
  ) dut (
    .clk_in   (clk),
    .rst_in   (rst),
    .cfg      (cfg_bus.slave),
    .clk_out  (clk_out),
    .tick_out (tick_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [3:0] d, input logic en);
    cfg_bus.cfg_wr_in  = 1'b1;
    cfg_bus.cfg_ch_in  = ch;
    cfg_bus.cfg_div_in = d;
    cfg_bus.cfg_en_in  = en;
    @(posedge clk);
    #1;
    cfg_bus.cfg_wr_in  = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ch3 runs D=15: high while count < 7, tick on count 14.
  task automatic chk_ch3(input string tag);
    chk({tag, "_clk3"},  {31'd0, clk_out[3]},  ((k3 % 15) < 7) ? 32'd1 : 32'd0);
    chk({tag, "_tick3"}, {31'd0, tick_out[3]}, ((k3 % 15) == 14) ? 32'd1 : 32'd0);
  endtask

  initial begin
    logic [8:0] e3_clk;
    logic [8:0] e3_tick;
    n_tests = 0;
    n_fail  = 0;
    k3      = 0;
    rst = 1'b1;
    cfg_bus.cfg_wr_in  = 1'b0;
    cfg_bus.cfg_ch_in  = 2'd0;
    cfg_bus.cfg_div_in = 4'd0;
    cfg_bus.cfg_en_in  = 1'b0;

    // 1: reset, then idle
    cyc(); cyc(); cyc();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("t1_idle", {23'd0, cfg_bus.cfg_err_out, tick_out, clk_out}, 32'd0);
    end

    // 2: ch0 D=4 -> clk 1,1,0,0 ; tick on the last low cycle
    wr(2'd0, 4'd4, 1'b1);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) cyc();
      chk("t2_clk0",  {31'd0, clk_out[0]},  ((k % 4) < 2) ? 32'd1 : 32'd0);
      chk("t2_tick0", {31'd0, tick_out[0]}, ((k % 4) == 3) ? 32'd1 : 32'd0);
    end
    chk("t2_err", {31'd0, cfg_bus.cfg_err_out}, 32'd0);

    // 3: ch1 D=5, retune to D=3 at cnt 1->2; counts 2,3,4 | 0,1,2 | 0,1,2
    wr(2'd1, 4'd5, 1'b1);
    chk("t3_en_clk1", {31'd0, clk_out[1]}, 32'd1);
    cyc();
    chk("t3_c1_clk1",  {31'd0, clk_out[1]},  32'd1);
    chk("t3_c1_tick1", {31'd0, tick_out[1]}, 32'd0);
    e3_clk  = 9'b001001000;
    e3_tick = 9'b100100100;
    wr(2'd1, 4'd3, 1'b1);
    for (int j = 0; j < 9; j++) begin
      if (j > 0) cyc();
      chk("t3_clk1",  {31'd0, clk_out[1]},  {31'd0, e3_clk[j]});
      chk("t3_tick1", {31'd0, tick_out[1]}, {31'd0, e3_tick[j]});
    end

    // 4: rejected writes pulse the error flag and change nothing
    wr(2'd2, 4'd1, 1'b1);
    chk("t4_err_d1", {31'd0, cfg_bus.cfg_err_out}, 32'd1);
    chk("t4_ch2_a",  {30'd0, tick_out[2], clk_out[2]}, 32'd0);
    cyc();
    chk("t4_err_clr", {31'd0, cfg_bus.cfg_err_out}, 32'd0);
    wr(2'd3, 4'd0, 1'b1);
    chk("t4_err_d0", {31'd0, cfg_bus.cfg_err_out}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t4_ch23", {28'd0, tick_out[3:2], clk_out[3:2]}, 32'd0);
    end
    chk("t4_err_end", {31'd0, cfg_bus.cfg_err_out}, 32'd0);

    // 5: ch0 at D=2 and ch3 at D=15; disabling ch0 leaves ch3 untouched
    wr(2'd0, 4'd2, 1'b0);
    chk("t5_off0", {30'd0, tick_out[0], clk_out[0]}, 32'd0);
    wr(2'd0, 4'd2, 1'b1);
    chk("t5_on0", {30'd0, tick_out[0], clk_out[0]}, 32'd1);
    wr(2'd3, 4'd15, 1'b1);
    k3 = 0;
    chk("t5_d2_lo", {30'd0, tick_out[0], clk_out[0]}, 32'd2);
    chk_ch3("t5_k0");
    wr(2'd0, 4'd2, 1'b0);
    k3 = 1;
    chk("t5_dis0", {30'd0, tick_out[0], clk_out[0]}, 32'd0);
    chk("t5_err",  {31'd0, cfg_bus.cfg_err_out}, 32'd0);
    chk_ch3("t5_k1");
    for (int i = 0; i < 20; i++) begin
      cyc();
      k3++;
      chk_ch3("t5_run");
      chk("t5_held0", {30'd0, tick_out[0], clk_out[0]}, 32'd0);
    end

    // 6: one-cycle reset mid-period with a coincident valid write
    rst = 1'b1;
    wr(2'd2, 4'd3, 1'b1);
    rst = 1'b0;
    chk("t6_rst", {23'd0, cfg_bus.cfg_err_out, tick_out, clk_out}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("t6_after", {23'd0, cfg_bus.cfg_err_out, tick_out, clk_out}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
